// File: rtl/urf_altitude_filter_if.sv
// rtl/urf_altitude_filter_if.sv - range-finder input and filtered altitude output bundle
// The range finder (or bench) drives through master; the filter uses slave.
interface urf_altitude_filter_if;
  logic [9:0]         urf_range;
  logic               urf_valid;
  logic               complete_signal;
  logic [9:0]         altitude;
  logic               altitude_valid;
  logic               altitude_strobe;
  logic               sample_rejected;
  logic signed [10:0] climb_rate;

  modport slave (
    input  urf_range, urf_valid, complete_signal,
    output altitude, altitude_valid, altitude_strobe, sample_rejected, climb_rate
  );

  modport master (
    output urf_range, urf_valid, complete_signal,
    input  altitude, altitude_valid, altitude_strobe, sample_rejected, climb_rate
  );
endinterface

// File: rtl/urf_altitude_filter.sv
// rtl/urf_altitude_filter.sv - spike rejection and 4-sample moving average of ultrasonic range
// Optional climb-rate output is enabled by defining URF_CLIMB_RATE_EN.
module urf_altitude_filter #(
  parameter int MAX_STEP     = 30,
  parameter int REJECT_LIMIT = 3,
  parameter int MISS_LIMIT   = 4
) (
  input logic                   us_clk,
  input logic                   resetn,
  urf_altitude_filter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_UPDATE, S_OUTPUT} state_t;
  typedef enum logic [1:0] {K_INVALID, K_SEED, K_ACCEPT, K_REJECT} kind_t;

  localparam logic [10:0] STEP_LIM = 11'(MAX_STEP);
  localparam logic [7:0]  REJ_LIM  = 8'(REJECT_LIMIT);
  localparam logic [7:0]  MISS_LIM = 8'(MISS_LIMIT);

  state_t      state, state_nxt;
  kind_t       kind;
  logic        comp_q;
  logic        edge_det;
  logic        latch_en, check_en, update_en, output_en;
  logic [9:0]  s_range;
  logic        s_valid;
  logic [9:0]  win [4];
  logic [1:0]  wp;
  logic        seeded;
  logic [7:0]  rej_cnt, miss_cnt;
  logic [10:0] diff;
  logic [11:0] sum;
  logic [9:0]  avg_n, avg_q;
  logic [9:0]  alt_q;
  logic        alt_valid_q, strobe_q, rejected_q;

  assign edge_det = bus.complete_signal & ~comp_q;

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (edge_det) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = S_OUTPUT;
      S_OUTPUT: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    latch_en  = 1'b0;
    check_en  = 1'b0;
    update_en = 1'b0;
    output_en = 1'b0;
    unique case (state)
      S_IDLE:   latch_en  = edge_det;
      S_CHECK:  check_en  = 1'b1;
      S_UPDATE: update_en = 1'b1;
      S_OUTPUT: output_en = 1'b1;
    endcase
  end

  // Reset to 1 so a signal already high at reset release is not taken as an edge.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      comp_q  <= 1'b1;
      s_range <= '0;
      s_valid <= 1'b0;
    end else begin
      comp_q <= bus.complete_signal;
      if (latch_en) begin
        s_range <= bus.urf_range;
        s_valid <= bus.urf_valid;
      end
    end
  end

  always_comb begin
    if (s_range >= alt_q) diff = {1'b0, s_range} - {1'b0, alt_q};
    else                  diff = {1'b0, alt_q} - {1'b0, s_range};
  end

  assign sum   = {2'b00, win[0]} + {2'b00, win[1]} + {2'b00, win[2]} + {2'b00, win[3]};
  assign avg_n = 10'((sum + 12'd2) >> 2);

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) win[i] <= '0;
      wp       <= '0;
      seeded   <= 1'b0;
      rej_cnt  <= '0;
      miss_cnt <= '0;
      kind     <= K_INVALID;
    end else if (check_en) begin
      if (!s_valid) begin
        kind <= K_INVALID;
        if (miss_cnt < MISS_LIM) miss_cnt <= miss_cnt + 8'd1;
        if (miss_cnt + 8'd1 >= MISS_LIM) seeded <= 1'b0;
      end else if (!seeded || (diff > STEP_LIM && rej_cnt + 8'd1 >= REJ_LIM)) begin
        kind <= K_SEED;
        for (int i = 0; i < 4; i++) win[i] <= s_range;
        seeded   <= 1'b1;
        rej_cnt  <= '0;
        miss_cnt <= '0;
      end else if (diff <= STEP_LIM) begin
        kind     <= K_ACCEPT;
        win[wp]  <= s_range;
        wp       <= wp + 2'd1;
        rej_cnt  <= '0;
        miss_cnt <= '0;
      end else begin
        kind     <= K_REJECT;
        rej_cnt  <= rej_cnt + 8'd1;
        miss_cnt <= '0;
      end
    end
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn)        avg_q <= '0;
    else if (update_en) avg_q <= avg_n;
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      alt_q       <= '0;
      alt_valid_q <= 1'b0;
      strobe_q    <= 1'b0;
      rejected_q  <= 1'b0;
    end else begin
      strobe_q   <= output_en;
      rejected_q <= output_en && (kind == K_REJECT);
      if (output_en) begin
        if (kind == K_SEED || kind == K_ACCEPT) alt_q <= avg_q;
        alt_valid_q <= seeded;
      end
    end
  end

`ifdef URF_CLIMB_RATE_EN
  logic signed [10:0] climb_q;

  // alt_q still holds the previous altitude while in S_OUTPUT.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) climb_q <= '0;
    else if (output_en) begin
      if (kind == K_ACCEPT) climb_q <= $signed({1'b0, avg_q}) - $signed({1'b0, alt_q});
      else                  climb_q <= '0;
    end
  end

  assign bus.climb_rate = climb_q;
`else
  assign bus.climb_rate = '0;
`endif

  assign bus.altitude        = alt_q;
  assign bus.altitude_valid  = alt_valid_q;
  assign bus.altitude_strobe = strobe_q;
  assign bus.sample_rejected = rejected_q;

endmodule

// File: tb/tb_urf_altitude_filter.sv
// tb/tb_urf_altitude_filter.sv - self-checking bench for urf_altitude_filter
// Directed scenarios plus randomized events against a behavioural model; honours URF_CLIMB_RATE_EN.
module tb_urf_altitude_filter;

  localparam int MAX_STEP     = 30;
  localparam int REJECT_LIMIT = 3;
  localparam int MISS_LIMIT   = 4;

  logic us_clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  urf_altitude_filter_if bus ();

  urf_altitude_filter #(
    .MAX_STEP(MAX_STEP), .REJECT_LIMIT(REJECT_LIMIT), .MISS_LIMIT(MISS_LIMIT)
  ) dut (
    .us_clk (us_clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 us_clk = ~us_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Behavioural model: window as a plain array, altitude as the rounded mean.
  int m_win [4];
  int m_wp, m_rej, m_miss, m_alt, m_climb;
  bit m_seeded, m_valid, m_rejpulse;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_win[i] = 0;
    m_wp = 0; m_rej = 0; m_miss = 0; m_alt = 0; m_climb = 0;
    m_seeded = 0; m_valid = 0; m_rejpulse = 0;
  endtask

  task automatic model_event(input int r, input bit v);
    int d, old, s;
    old = m_alt;
    m_rejpulse = 0;
    m_climb = 0;
    if (!v) begin
      if (m_miss < MISS_LIMIT) m_miss++;
      if (m_miss == MISS_LIMIT) m_seeded = 0;
    end else begin
      d = (r > m_alt) ? r - m_alt : m_alt - r;
      if (m_seeded && d <= MAX_STEP) begin
        m_win[m_wp] = r;
        m_wp = (m_wp + 1) % 4;
        m_rej = 0; m_miss = 0;
        s = m_win[0] + m_win[1] + m_win[2] + m_win[3];
        m_alt = (s + 2) / 4;
        m_climb = m_alt - old;
      end else if (m_seeded && m_rej + 1 < REJECT_LIMIT) begin
        m_rej++; m_miss = 0; m_rejpulse = 1;
      end else begin
        for (int i = 0; i < 4; i++) m_win[i] = r;
        m_seeded = 1; m_rej = 0; m_miss = 0; m_alt = r;
      end
    end
    m_valid = m_seeded;
`ifndef URF_CLIMB_RATE_EN
    m_climb = 0;
`endif
  endtask

  task automatic apply_reset();
    @(negedge us_clk);
    resetn = 1'b0;
    bus.complete_signal = 1'b0;
    bus.urf_valid = 1'b0;
    bus.urf_range = '0;
    repeat (2) @(negedge us_clk);
    resetn = 1'b1;
    model_reset();
    repeat (2) @(negedge us_clk);
  endtask

  task automatic do_event(input int r, input bit v, input string tag);
    int lat = 0;
    @(negedge us_clk);
    bus.urf_range = 10'(r);
    bus.urf_valid = v;
    bus.complete_signal = 1'b1;
    model_event(r, v);
    for (int k = 1; k <= 10; k++) begin
      @(posedge us_clk); #1;
      if (k == 2) bus.complete_signal = 1'b0;
      if (bus.altitude_strobe) begin lat = k; break; end
    end
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL %s latency: got %0d expected 4", tag, lat); end
    n_checks++;
    if (int'(bus.altitude) !== m_alt) begin
      n_fail++; $display("FAIL %s altitude: got %0d expected %0d", tag, bus.altitude, m_alt);
    end
    n_checks++;
    if (bus.altitude_valid !== m_valid) begin
      n_fail++; $display("FAIL %s altitude_valid: got %0b expected %0b", tag, bus.altitude_valid, m_valid);
    end
    n_checks++;
    if (bus.sample_rejected !== m_rejpulse) begin
      n_fail++; $display("FAIL %s sample_rejected: got %0b expected %0b", tag, bus.sample_rejected, m_rejpulse);
    end
    n_checks++;
    if (int'(bus.climb_rate) !== m_climb) begin
      n_fail++; $display("FAIL %s climb_rate: got %0d expected %0d", tag, bus.climb_rate, m_climb);
    end
    @(posedge us_clk); #1;
    n_checks++;
    if (bus.altitude_strobe !== 1'b0 || bus.sample_rejected !== 1'b0) begin
      n_fail++; $display("FAIL %s pulse width: strobe %0b rejected %0b expected 0 0", tag,
                         bus.altitude_strobe, bus.sample_rejected);
    end
    n_checks++;
    if (int'(bus.altitude) !== m_alt) begin
      n_fail++; $display("FAIL %s altitude hold: got %0d expected %0d", tag, bus.altitude, m_alt);
    end
    repeat (2) @(posedge us_clk);
  endtask

  task automatic test_reset();
    bus.urf_range = '0; bus.urf_valid = 1'b0; bus.complete_signal = 1'b0;
    resetn = 1'b0;
    repeat (3) @(negedge us_clk);
    n_checks++;
    if (bus.altitude !== 10'd0 || bus.altitude_valid !== 1'b0 || bus.altitude_strobe !== 1'b0 ||
        bus.sample_rejected !== 1'b0 || bus.climb_rate !== 11'sd0) begin
      n_fail++; $display("FAIL reset outputs: alt %0d valid %0b strobe %0b rej %0b climb %0d expected all 0",
                         bus.altitude, bus.altitude_valid, bus.altitude_strobe, bus.sample_rejected, bus.climb_rate);
    end
    resetn = 1'b1;
    model_reset();
    repeat (2) @(negedge us_clk);
  endtask

  task automatic test_seed_accept();
    int exp_alt [4] = '{100, 101, 103, 106};
    int samples [4] = '{100, 104, 108, 112};
    for (int i = 0; i < 4; i++) begin
      do_event(samples[i], 1'b1, "seed_accept");
      n_checks++;
      if (int'(bus.altitude) !== exp_alt[i] || bus.altitude_valid !== 1'b1) begin
        n_fail++; $display("FAIL seed_accept step %0d: alt %0d valid %0b expected %0d 1",
                           i, bus.altitude, bus.altitude_valid, exp_alt[i]);
      end
    end
  endtask

  task automatic test_spike();
    apply_reset();
    repeat (4) do_event(200, 1'b1, "spike_settle");
    do_event(300, 1'b1, "spike");
    n_checks++;
    if (bus.sample_rejected !== 1'b0 || int'(bus.altitude) !== 200 || bus.climb_rate !== 11'sd0) begin
      n_fail++; $display("FAIL spike hold: alt %0d climb %0d expected 200 0", bus.altitude, bus.climb_rate);
    end
    do_event(200, 1'b1, "spike_recover");
    do_event(300, 1'b1, "spike_again1");
    do_event(300, 1'b1, "spike_again2");
    n_checks++;
    if (int'(bus.altitude) !== 200) begin
      n_fail++; $display("FAIL spike reject_cnt clear: alt %0d expected 200", bus.altitude);
    end
  endtask

  task automatic test_boundary();
    apply_reset();
    do_event(200, 1'b1, "bound_seed");
    do_event(200 + MAX_STEP, 1'b1, "bound_at_step");
    n_checks++;
    if (int'(bus.altitude) !== 208) begin
      n_fail++; $display("FAIL bound_at_step altitude: got %0d expected 208", bus.altitude);
    end
    do_event(208 + MAX_STEP + 1, 1'b1, "bound_over_step");
    do_event(1023, 1'b1, "bound_max_range");
  endtask

  task automatic test_reseed_and_loss();
    apply_reset();
    repeat (2) do_event(200, 1'b1, "reseed_settle");
    do_event(50, 1'b1, "reseed_rej1");
    do_event(50, 1'b1, "reseed_rej2");
    do_event(50, 1'b1, "reseed_seed");
    n_checks++;
    if (int'(bus.altitude) !== 50 || bus.climb_rate !== 11'sd0 || bus.sample_rejected !== 1'b0) begin
      n_fail++; $display("FAIL reseed: alt %0d climb %0d expected 50 0", bus.altitude, bus.climb_rate);
    end
    for (int i = 0; i < 4; i++) do_event(0, 1'b0, "loss");
    n_checks++;
    if (bus.altitude_valid !== 1'b0 || int'(bus.altitude) !== 50) begin
      n_fail++; $display("FAIL loss: valid %0b alt %0d expected 0 50", bus.altitude_valid, bus.altitude);
    end
    do_event(80, 1'b1, "loss_reseed");
    n_checks++;
    if (bus.altitude_valid !== 1'b1 || int'(bus.altitude) !== 80) begin
      n_fail++; $display("FAIL loss_reseed: valid %0b alt %0d expected 1 80", bus.altitude_valid, bus.altitude);
    end
  endtask

  task automatic test_climb();
    int exp_climb;
`ifdef URF_CLIMB_RATE_EN
    exp_climb = 5;
`else
    exp_climb = 0;
`endif
    apply_reset();
    repeat (4) do_event(100, 1'b1, "climb_settle");
    do_event(120, 1'b1, "climb");
    n_checks++;
    if (int'(bus.climb_rate) !== exp_climb || int'(bus.altitude) !== 105) begin
      n_fail++; $display("FAIL climb: rate %0d alt %0d expected %0d 105", bus.climb_rate, bus.altitude, exp_climb);
    end
  endtask

  task automatic test_edge_corner();
    int strobes = 0;
    int lat = 0;
    apply_reset();
    @(negedge us_clk);
    bus.urf_range = 10'd100; bus.urf_valid = 1'b1; bus.complete_signal = 1'b1;
    model_event(100, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      @(posedge us_clk); #1;
      if (k == 1) bus.complete_signal = 1'b0;
      if (k == 2) bus.complete_signal = 1'b1;
      if (k == 6) bus.complete_signal = 1'b0;
      if (bus.altitude_strobe) begin strobes++; if (lat == 0) lat = k; end
    end
    n_checks++;
    if (strobes !== 1 || lat !== 4) begin
      n_fail++; $display("FAIL edge_ignore: strobes %0d first at %0d expected 1 at 4", strobes, lat);
    end
    n_checks++;
    if (int'(bus.altitude) !== 100) begin
      n_fail++; $display("FAIL edge_ignore altitude: got %0d expected 100", bus.altitude);
    end
    @(negedge us_clk);
    bus.urf_range = 10'd150; bus.complete_signal = 1'b1;
    @(posedge us_clk); #1;
    @(posedge us_clk); #1;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (bus.altitude !== 10'd0 || bus.altitude_valid !== 1'b0 || bus.altitude_strobe !== 1'b0 ||
        bus.sample_rejected !== 1'b0 || bus.climb_rate !== 11'sd0) begin
      n_fail++; $display("FAIL mid_reset outputs: alt %0d valid %0b expected 0 0", bus.altitude, bus.altitude_valid);
    end
    repeat (2) @(negedge us_clk);
    resetn = 1'b1;
    model_reset();
    strobes = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge us_clk); #1;
      if (bus.altitude_strobe) strobes++;
    end
    n_checks++;
    if (strobes !== 0) begin
      n_fail++; $display("FAIL mid_reset strobe: got %0d strobes expected 0", strobes);
    end
    bus.complete_signal = 1'b0;
    repeat (2) @(posedge us_clk);
    do_event(70, 1'b1, "after_reset");
  endtask

  task automatic test_random();
    int r, sel;
    bit v;
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      v = ($urandom_range(0, 9) != 0);
      sel = $urandom_range(0, 99);
      if (sel < 70) r = m_alt + $urandom_range(0, 2 * MAX_STEP + 4) - (MAX_STEP + 2);
      else          r = $urandom_range(0, 1023);
      if (r < 0) r = 0;
      if (r > 1023) r = 1023;
      do_event(r, v, "random");
    end
  endtask

  initial begin
    test_reset();
    test_seed_accept();
    test_spike();
    test_boundary();
    test_reseed_and_loss();
    test_climb();
    test_edge_corner();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
